// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: BCD up/down event timer with a four-state run controller.
// Counts tick pulses in BCD from a start value towards a terminal value.
// Down mode counts target -> 0 and up mode counts 0 -> target.
// Supports start/pause toggling, clear, and a target register that is
// loadable only while idle or done. Every output is registered.
module bcd_timer_ctrl #(
    parameter int                  DIGITS = 2,
    parameter logic [4*DIGITS-1:0] PRESET = 8'h30,
    parameter int                  LED_W  = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,        // active-high asynchronous reset despite the name
    input  logic                  tick,
    input  logic                  start_pause,
    input  logic                  clear,
    input  logic                  up_mode,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  done,
    output logic [LED_W-1:0]      endled
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       target_q, target_d;
    logic [W-1:0]       count_q, count_d;
    logic               dir_q, dir_d;          // 1 = counting up, latched when leaving IDLE
    logic               running_q;
    logic               done_q;
    logic [LED_W-1:0]   endled_q;

    // Per-digit BCD arithmetic on the current count, plus load saturation
    logic [DIGITS-1:0]  carry;                 // carry into each digit for +1
    logic [DIGITS-1:0]  borrow;                // borrow into each digit for -1
    logic [W-1:0]       count_inc;
    logic [W-1:0]       count_dec;
    logic [W-1:0]       load_sat;

    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] dig;
            logic [3:0] ld_dig;

            assign dig    = count_q[4*gi +: 4];
            assign ld_dig = load_val[4*gi +: 4];

            // Up: a 9 rolls to 0 and carries into the next digit
            assign count_inc[4*gi +: 4] = carry[gi]
                                        ? ((dig >= 4'd9) ? 4'd0 : dig + 4'd1)
                                        : dig;

            // Down: a 0 borrows to 9 and decrements the next digit
            assign count_dec[4*gi +: 4] = borrow[gi]
                                        ? ((dig == 4'd0) ? 4'd9 : dig - 4'd1)
                                        : dig;

            // Any non-decimal nibble written to the target is clamped to 9
            assign load_sat[4*gi +: 4] = (ld_dig > 4'd9) ? 4'd9 : ld_dig;

            if (gi < DIGITS - 1) begin : g_chain
                assign carry[gi+1]  = carry[gi]  & (dig >= 4'd9);
                assign borrow[gi+1] = borrow[gi] & (dig == 4'd0);
            end
        end
    endgenerate

    // Start value follows the live up_mode (used in IDLE and on clear);
    // the terminal while running or done follows the latched direction.
    logic [W-1:0] start_val;
    logic [W-1:0] run_term;
    logic [W-1:0] step_val;
    logic         target_zero;

    assign start_val   = up_mode ? '0 : target_q;
    assign run_term    = dir_q ? target_q : '0;
    assign step_val    = dir_q ? count_inc : count_dec;
    assign target_zero = (target_q == '0);

    // Next-state, next-count, target and direction selection
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        count_d  = count_q;
        dir_d    = dir_q;

        if (clear) begin
            // Clear overrides every other command; the target is untouched
            state_d = ST_IDLE;
            count_d = start_val;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    count_d = start_val;
                    if (start_pause) begin
                        // A start outranks a same-cycle load so that the run
                        // begins from the value already on the display
                        dir_d   = up_mode;
                        state_d = target_zero ? ST_DONE : ST_RUN;
                    end else if (load) begin
                        target_d = load_sat;
                    end
                end

                ST_RUN: begin
                    if (tick) begin
                        count_d = step_val;
                    end
                    if (tick && (step_val == run_term)) begin
                        state_d = ST_DONE;
                    end else if (start_pause) begin
                        state_d = ST_PAUSE;
                    end
                end

                ST_PAUSE: begin
                    if (start_pause) begin
                        state_d = ST_RUN;
                    end
                end

                ST_DONE: begin
                    count_d = run_term;
                    if (load) begin
                        target_d = load_sat;
                        state_d  = ST_IDLE;
                    end else if (start_pause) begin
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= ST_IDLE;
            target_q  <= PRESET;
            count_q   <= PRESET;
            dir_q     <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            endled_q  <= '0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            count_q   <= count_d;
            dir_q     <= dir_d;
            running_q <= (state_d == ST_RUN);
            done_q    <= (state_d == ST_DONE);
            endled_q  <= {LED_W{state_d == ST_DONE}};
        end
    end

    assign count   = count_q;
    assign running = running_q;
    assign done    = done_q;
    assign endled  = endled_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Testbench for bcd_timer_ctrl: directed scenarios plus randomized traffic
// checked against a decimal-integer reference model.
module tb_bcd_timer_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        start_pause = 1'b0;
    logic        clear = 1'b0;
    logic        up_mode = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  load_val = 8'h00;
    logic [7:0]  count;
    logic        running;
    logic        done;
    logic [14:0] endled;

    int checks = 0;
    int errors = 0;

    // Reference model: plain decimal integers and a mode number
    // (0 idle, 1 run, 2 pause, 3 done)
    int m_state;
    int m_target;
    int m_count;
    bit m_dir;

    always #5 clk = ~clk;

    bcd_timer_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .start_pause (start_pause),
        .clear       (clear),
        .up_mode     (up_mode),
        .load        (load),
        .load_val    (load_val),
        .count       (count),
        .running     (running),
        .done        (done),
        .endled      (endled)
    );

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(v / 10);
        ones = 4'(v % 10);
        return {tens, ones};
    endfunction

    function automatic int sat_val(input logic [7:0] lv);
        int hi;
        int lo;
        hi = int'(lv[7:4]);
        lo = int'(lv[3:0]);
        if (hi > 9) hi = 9;
        if (lo > 9) lo = 9;
        return hi * 10 + lo;
    endfunction

    task automatic model_reset();
        m_state  = 0;
        m_target = 30;
        m_count  = 30;
        m_dir    = 1'b0;
    endtask

    task automatic model_update(input bit tk, input bit sp, input bit clr,
                                input bit um, input bit ld, input logic [7:0] lv);
        int start_v;
        int term;
        start_v = um ? 0 : m_target;
        term    = m_dir ? m_target : 0;
        if (clr) begin
            m_state = 0;
            m_count = start_v;
        end else begin
            case (m_state)
                0: begin
                    m_count = start_v;
                    if (sp) begin
                        m_dir   = um;
                        m_state = (m_target == 0) ? 3 : 1;
                    end else if (ld) begin
                        m_target = sat_val(lv);
                    end
                end
                1: begin
                    if (tk) m_count = m_dir ? m_count + 1 : m_count - 1;
                    if (tk && m_count == term) m_state = 3;
                    else if (sp) m_state = 2;
                end
                2: begin
                    if (sp) m_state = 1;
                end
                default: begin
                    if (ld) begin
                        m_target = sat_val(lv);
                        m_state  = 0;
                    end else if (sp) begin
                        m_state = 0;
                    end
                end
            endcase
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, settle
    task automatic step(input bit tk, input bit sp, input bit clr,
                        input bit um, input bit ld, input logic [7:0] lv);
        tick        = tk;
        start_pause = sp;
        clear       = clr;
        up_mode     = um;
        load        = ld;
        load_val    = lv;
        @(posedge clk);
        model_update(tk, sp, clr, um, ld, lv);
        #1;
        tick        = 1'b0;
        start_pause = 1'b0;
        clear       = 1'b0;
        load        = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b1;
        #1;
        checks++;
        if (count !== 8'h30 || running !== 1'b0 || done !== 1'b0 || endled !== 15'h0) begin
            errors++;
            $display("FAIL reset_async: count=%h run=%b done=%b led=%h, required 30 0 0 0000",
                     count, running, done, endled);
        end
        @(posedge clk);
        #1;
        checks++;
        if (count !== 8'h30 || running !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: count=%h run=%b, required 30 0", count, running);
        end
        rst_n = 1'b0;
        model_reset();
        $display("reset released: count=%h", count);
    endtask

    task automatic test_countdown();
        logic [14:0] exp_led;
        step(0, 1, 0, 0, 0, 8'h00);
        checks++;
        if (count !== 8'h30 || running !== 1'b1) begin
            errors++;
            $display("FAIL down_start: count=%h run=%b, required 30 1", count, running);
        end
        for (int i = 1; i <= 30; i++) begin
            step(1, 0, 0, 0, 0, 8'h00);
            exp_led = (i == 30) ? 15'h7FFF : 15'h0000;
            checks++;
            if (count !== to_bcd(30 - i) || running !== (i < 30) || done !== (i == 30)
                || endled !== exp_led) begin
                errors++;
                $display("FAIL down_tick%0d: count=%h run=%b done=%b led=%h, required %h %b %b %h",
                         i, count, running, done, endled, to_bcd(30 - i), (i < 30), (i == 30), exp_led);
            end
            $display("down tick %0d: count=%h run=%b done=%b", i, count, running, done);
        end
        step(1, 0, 0, 0, 0, 8'h00);
        checks++;
        if (count !== 8'h00 || done !== 1'b1) begin
            errors++;
            $display("FAIL down_hold: count=%h done=%b, required 00 1", count, done);
        end
        step(0, 1, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 0, 8'h00);
        checks++;
        if (count !== 8'h30 || done !== 1'b0 || endled !== 15'h0) begin
            errors++;
            $display("FAIL down_to_idle: count=%h done=%b led=%h, required 30 0 0000", count, done, endled);
        end
    endtask

    task automatic test_countup();
        step(0, 0, 0, 1, 1, 8'h12);
        step(0, 0, 0, 1, 0, 8'h00);
        checks++;
        if (count !== 8'h00) begin
            errors++;
            $display("FAIL up_idle: count=%h, required 00", count);
        end
        step(0, 1, 0, 1, 0, 8'h00);
        for (int i = 1; i <= 12; i++) begin
            step(1, 0, 0, 1, 0, 8'h00);
            checks++;
            if (count !== to_bcd(i) || done !== (i == 12) || running !== (i < 12)) begin
                errors++;
                $display("FAIL up_tick%0d: count=%h done=%b run=%b, required %h %b %b",
                         i, count, done, running, to_bcd(i), (i == 12), (i < 12));
            end
            $display("up tick %0d: count=%h done=%b", i, count, done);
        end
        // Flip up_mode while done: the latched direction must be kept
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 8'h00);
        checks++;
        if (count !== 8'h12 || done !== 1'b1) begin
            errors++;
            $display("FAIL up_hold: count=%h done=%b, required 12 1", count, done);
        end
        step(0, 1, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 0, 8'h00);
        checks++;
        if (count !== 8'h12 || done !== 1'b0) begin
            errors++;
            $display("FAIL up_to_idle_down: count=%h done=%b, required 12 0", count, done);
        end
        step(0, 0, 0, 0, 1, 8'h30);
        step(0, 0, 0, 0, 0, 8'h00);
    endtask

    task automatic test_pause();
        step(0, 1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 8'h00);
        checks++;
        if (count !== 8'h25) begin
            errors++;
            $display("FAIL pause_pre: count=%h, required 25", count);
        end
        step(1, 1, 0, 0, 0, 8'h00);
        checks++;
        if (count !== 8'h24 || running !== 1'b0) begin
            errors++;
            $display("FAIL pause_enter: count=%h run=%b, required 24 0", count, running);
        end
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 8'h00);
        checks++;
        if (count !== 8'h24 || running !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL pause_hold: count=%h run=%b done=%b, required 24 0 0", count, running, done);
        end
        step(1, 1, 0, 0, 0, 8'h00);
        checks++;
        if (count !== 8'h24 || running !== 1'b1) begin
            errors++;
            $display("FAIL pause_resume: count=%h run=%b, required 24 1", count, running);
        end
        step(1, 0, 0, 0, 0, 8'h00);
        checks++;
        if (count !== 8'h23) begin
            errors++;
            $display("FAIL pause_next: count=%h, required 23", count);
        end
        step(0, 0, 1, 0, 0, 8'h00);
        checks++;
        if (count !== 8'h30 || running !== 1'b0) begin
            errors++;
            $display("FAIL pause_clear: count=%h run=%b, required 30 0", count, running);
        end
        $display("pause scenario: count=%h", count);
    endtask

    task automatic test_load_clear();
        step(0, 0, 0, 0, 1, 8'hA7);
        step(0, 0, 0, 0, 0, 8'h00);
        checks++;
        if (count !== 8'h97) begin
            errors++;
            $display("FAIL load_sat: count=%h, required 97", count);
        end
        step(0, 1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 1, 8'h05);
        checks++;
        if (count !== 8'h96 || running !== 1'b1) begin
            errors++;
            $display("FAIL load_in_run: count=%h run=%b, required 96 1", count, running);
        end
        step(0, 1, 1, 0, 0, 8'h00);
        checks++;
        if (count !== 8'h97 || running !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL clear_prio: count=%h run=%b done=%b, required 97 0 0", count, running, done);
        end
        step(0, 0, 0, 0, 0, 8'h00);
        checks++;
        if (count !== 8'h97) begin
            errors++;
            $display("FAIL target_kept: count=%h, required 97", count);
        end
        step(0, 0, 0, 1, 0, 8'h00);
        checks++;
        if (count !== 8'h00) begin
            errors++;
            $display("FAIL idle_track_up: count=%h, required 00", count);
        end
        $display("load/clear scenario: count=%h", count);
    endtask

    task automatic test_zero_and_reset();
        step(0, 0, 0, 0, 1, 8'h00);
        step(0, 1, 0, 0, 0, 8'h00);
        checks++;
        if (count !== 8'h00 || done !== 1'b1 || endled !== 15'h7FFF || running !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: count=%h done=%b led=%h run=%b, required 00 1 7fff 0",
                     count, done, endled, running);
        end
        step(0, 0, 0, 0, 1, 8'h45);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_load_idle: done=%b, required 0", done);
        end
        step(0, 0, 0, 0, 0, 8'h00);
        step(0, 1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 8'h00);
        checks++;
        if (count !== 8'h42 || running !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_run: count=%h run=%b, required 42 1", count, running);
        end
        #2 rst_n = 1'b1;
        #1;
        checks++;
        if (count !== 8'h30 || running !== 1'b0 || done !== 1'b0 || endled !== 15'h0) begin
            errors++;
            $display("FAIL midrun_reset: count=%h run=%b done=%b led=%h, required 30 0 0 0000",
                     count, running, done, endled);
        end
        model_reset();
        #1 rst_n = 1'b0;
        step(1, 0, 0, 0, 0, 8'h00);
        checks++;
        if (count !== 8'h30 || running !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: count=%h run=%b, required 30 0", count, running);
        end
        step(0, 1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 0, 8'h00);
        checks++;
        if (count !== 8'h29 || running !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_run: count=%h run=%b, required 29 1", count, running);
        end
        step(0, 0, 1, 0, 0, 8'h00);
        $display("zero/reset scenario: count=%h", count);
    endtask

    task automatic test_random();
        bit          tk, sp, clr, um, ld;
        logic [7:0]  lv;
        logic [14:0] exp_led;
        um = 1'b0;
        for (int n = 0; n < 600; n++) begin
            tk  = ($urandom_range(0, 1) == 1);
            sp  = ($urandom_range(0, 7) == 0);
            clr = ($urandom_range(0, 59) == 0);
            ld  = ($urandom_range(0, 11) == 0);
            lv  = 8'($urandom);
            if ($urandom_range(0, 15) == 0) um = ~um;
            step(tk, sp, clr, um, ld, lv);
            exp_led = (m_state == 3) ? 15'h7FFF : 15'h0000;
            checks++;
            if (count !== to_bcd(m_count) || running !== (m_state == 1) ||
                done !== (m_state == 3) || endled !== exp_led) begin
                errors++;
                $display("FAIL rand%0d: count=%h run=%b done=%b led=%h, required %h %b %b %h",
                         n, count, running, done, endled, to_bcd(m_count),
                         (m_state == 1), (m_state == 3), exp_led);
            end
            $display("rand %0d: tk=%b sp=%b clr=%b um=%b ld=%b lv=%h -> count=%h run=%b done=%b",
                     n, tk, sp, clr, um, ld, lv, count, running, done);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_countdown();
        test_countup();
        test_pause();
        test_load_clear();
        test_zero_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
